// File: rtl/insert_y_if.sv
// Handshake bus for insert_y: input word offer, fill digits, abort, and expanded-word output.
interface insert_y_if #(
  parameter int N = 128,
  parameter int M = 112
);
  logic           in_valid;
  logic           in_ready;
  logic [2*M-1:0] word_in;
  logic [6:0]     word_in_len;
  logic [31:0]    y_fill;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] word_out;
  logic           len_err;
  logic [15:0]    word_cnt;

  modport master (
    output in_valid, word_in, word_in_len, y_fill, flush, out_ready,
    input  in_ready, out_valid, word_out, len_err, word_cnt
  );

  modport slave (
    input  in_valid, word_in, word_in_len, y_fill, flush, out_ready,
    output in_ready, out_valid, word_out, len_err, word_cnt
  );
endinterface

// File: rtl/insert_y.sv
// Expands a 112-digit word to 128 digits by inserting 16 fill digits at fixed positions,
// building the output in three one-cycle segments.
module insert_y #(
  parameter int N = 128,
  parameter int M = 112
) (
  input  logic     clk,
  input  logic     rst_n,
  insert_y_if.slave bus
);

  localparam logic [6:0] M_LEN = 7'(M);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEG_LO  = 3'd1,
    SEG_MID = 3'd2,
    SEG_HI  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [2*M-1:0] word_r;
  logic [31:0]    fill_r;
  logic [6:0]     len_r;
  logic [2*N-1:0] word_out_r;
  logic           len_err_r;
  logic [15:0]    word_cnt_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_s = state_r;
    if (bus.flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    if (bus.in_valid) state_s = SEG_LO; else state_s = IDLE;
        SEG_LO:  state_s = SEG_MID;
        SEG_MID: state_s = SEG_HI;
        SEG_HI:  state_s = DONE;
        DONE:    if (bus.out_ready) state_s = IDLE; else state_s = DONE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Capture, segmented output assembly, length check and handshake counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r     <= '0;
      fill_r     <= 32'd0;
      len_r      <= 7'd0;
      word_out_r <= '0;
      len_err_r  <= 1'b0;
      word_cnt_r <= 16'd0;
    end else if (!bus.flush) begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            word_r <= bus.word_in;
            fill_r <= bus.y_fill;
            len_r  <= bus.word_in_len;
          end
        end
        SEG_LO:  word_out_r[33:0]    <= {fill_r[15:10], word_r[17:0], fill_r[9:0]};
        SEG_MID: word_out_r[129:34]  <= {fill_r[21:16], word_r[107:18]};
        SEG_HI: begin
          word_out_r[255:130] <= {fill_r[31:22], word_r[223:108]};
          len_err_r           <= (len_r != M_LEN);
        end
        DONE: begin
          // Counter saturates rather than wrapping
          if (bus.out_ready && (word_cnt_r != 16'hFFFF)) begin
            word_cnt_r <= word_cnt_r + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = (state_r == DONE);
  assign bus.word_out  = word_out_r;
  assign bus.len_err   = len_err_r;
  assign bus.word_cnt  = word_cnt_r;

endmodule

// File: tb/tb_insert_y.sv
// Directed self-checking bench for insert_y: layout, latency, stall, length error, flush, reset, saturation.
module tb_insert_y;

  logic clk;
  logic rst_n;
  int   chk_cnt;
  int   pass_cnt;
  logic [15:0]  exp_cnt;
  logic [223:0] w_ones;
  logic [223:0] w_mod4;
  logic [223:0] w_alt;
  logic [255:0] exp_w;

  insert_y_if #(.N(128), .M(112)) bus ();

  insert_y #(.N(128), .M(112)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [255:0] expand(input logic [223:0] w, input logic [31:0] f);
    logic [255:0] r;
    r = '0;
    for (int o = 0; o < 128; o++) begin
      if (o < 5)        r[2*o +: 2] = f[2*o +: 2];
      else if (o < 14)  r[2*o +: 2] = w[2*(o-5) +: 2];
      else if (o < 17)  r[2*o +: 2] = f[2*(o-14+5) +: 2];
      else if (o < 62)  r[2*o +: 2] = w[2*(o-17+9) +: 2];
      else if (o < 65)  r[2*o +: 2] = f[2*(o-62+8) +: 2];
      else if (o < 123) r[2*o +: 2] = w[2*(o-65+54) +: 2];
      else              r[2*o +: 2] = f[2*(o-123+11) +: 2];
    end
    return r;
  endfunction

  function automatic logic [1:0] dig(input logic [255:0] w, input int i);
    return w[2*i +: 2];
  endfunction

  task automatic accept(input logic [223:0] w, input logic [31:0] f, input logic [6:0] len);
    @(negedge clk);
    bus.word_in     = w;
    bus.y_fill      = f;
    bus.word_in_len = len;
    bus.in_valid    = 1'b1;
    @(negedge clk);
    bus.in_valid    = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check(tag, 256'(n), 256'd3);
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  initial begin
    chk_cnt = 0;
    pass_cnt = 0;
    exp_cnt = 16'd0;
    for (int k = 0; k < 112; k++) begin
      w_ones[2*k +: 2] = 2'b01;
      w_mod4[2*k +: 2] = 2'(k % 4);
      w_alt[2*k +: 2]  = 2'(3 - (k % 4));
    end
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.word_in     = '0;
    bus.word_in_len = 7'd0;
    bus.y_fill      = 32'd0;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_word_out", bus.word_out, 256'd0);
    check("rst_out_valid", 256'(bus.out_valid), 256'd0);
    check("rst_len_err", 256'(bus.len_err), 256'd0);
    check("rst_word_cnt", 256'(bus.word_cnt), 256'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 256'(bus.in_ready), 256'd1);

    // All-ones input, all-3 fill
    accept(w_ones, 32'hFFFF_FFFF, 7'd112);
    check("busy_in_ready", 256'(bus.in_ready), 256'd0);
    wait_valid("lat_ones");
    check("ones_d0", 256'(dig(bus.word_out, 0)), 256'd3);
    check("ones_d5", 256'(dig(bus.word_out, 5)), 256'd1);
    check("ones_d16", 256'(dig(bus.word_out, 16)), 256'd3);
    check("ones_d17", 256'(dig(bus.word_out, 17)), 256'd1);
    check("ones_d64", 256'(dig(bus.word_out, 64)), 256'd3);
    check("ones_d122", 256'(dig(bus.word_out, 122)), 256'd1);
    check("ones_d127", 256'(dig(bus.word_out, 127)), 256'd3);
    check("ones_word", bus.word_out, expand(w_ones, 32'hFFFF_FFFF));
    check("ones_len_err", 256'(bus.len_err), 256'd0);
    handshake();
    check("ones_cnt", 256'(bus.word_cnt), 256'd1);
    check("ones_idle_ready", 256'(bus.in_ready), 256'd1);
    check("ones_idle_valid", 256'(bus.out_valid), 256'd0);

    // k mod 4 input, zero fill; inputs change right after capture
    accept(w_mod4, 32'd0, 7'd112);
    bus.word_in = w_alt;
    bus.y_fill  = 32'hA5A5_5A5A;
    wait_valid("lat_mod4");
    check("mod4_d5", 256'(dig(bus.word_out, 5)), 256'd0);
    check("mod4_d13", 256'(dig(bus.word_out, 13)), 256'd0);
    check("mod4_d17", 256'(dig(bus.word_out, 17)), 256'd1);
    check("mod4_d65", 256'(dig(bus.word_out, 65)), 256'd2);
    check("mod4_d122", 256'(dig(bus.word_out, 122)), 256'd3);
    exp_w = expand(w_mod4, 32'd0);
    check("mod4_word", bus.word_out, exp_w);

    // Stall in DONE with inputs changing
    for (int i = 0; i < 10; i++) begin
      bus.word_in  = {7{32'(i * 32'h1357_9BDF)}};
      bus.y_fill   = 32'(i * 32'h0F0F_3C3C);
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("stall_word", bus.word_out, exp_w);
    check("stall_in_ready", 256'(bus.in_ready), 256'd0);
    check("stall_out_valid", 256'(bus.out_valid), 256'd1);
    check("stall_cnt", 256'(bus.word_cnt), 256'(exp_cnt));
    handshake();
    check("stall_cnt_after", 256'(bus.word_cnt), 256'(exp_cnt));
    check("stall_idle", 256'(bus.in_ready), 256'd1);

    // out_ready while idle is ignored
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b0;
    check("idle_ready_cnt", 256'(bus.word_cnt), 256'(exp_cnt));

    // Short declared length
    accept(w_alt, 32'h1234_5678, 7'd100);
    wait_valid("lat_len100");
    check("len100_err", 256'(bus.len_err), 256'd1);
    check("len100_word", bus.word_out, expand(w_alt, 32'h1234_5678));
    handshake();
    accept(w_ones, 32'h8765_4321, 7'd112);
    wait_valid("lat_len112");
    check("len112_err", 256'(bus.len_err), 256'd0);
    exp_w = expand(w_ones, 32'h8765_4321);
    check("len112_word", bus.word_out, exp_w);
    handshake();

    // Flush during SEG_MID
    accept(w_mod4, 32'hDEAD_BEEF, 7'd112);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_in_ready", 256'(bus.in_ready), 256'd1);
    check("flush_out_valid", 256'(bus.out_valid), 256'd0);
    check("flush_cnt", 256'(bus.word_cnt), 256'(exp_cnt));
    repeat (5) @(negedge clk);
    check("flush_no_valid", 256'(bus.out_valid), 256'd0);

    // Flush coinciding with the output handshake
    accept(w_alt, 32'h0000_FFFF, 7'd112);
    wait_valid("lat_flush_hs");
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    check("flush_hs_cnt", 256'(bus.word_cnt), 256'(exp_cnt));
    check("flush_hs_valid", 256'(bus.out_valid), 256'd0);
    check("flush_hs_word", bus.word_out, expand(w_alt, 32'h0000_FFFF));

    // Reset during SEG_HI
    accept(w_ones, 32'h5555_AAAA, 7'd99);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("hi_rst_word", bus.word_out, 256'd0);
    check("hi_rst_valid", 256'(bus.out_valid), 256'd0);
    check("hi_rst_len_err", 256'(bus.len_err), 256'd0);
    check("hi_rst_cnt", 256'(bus.word_cnt), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 16'd0;
    repeat (4) @(negedge clk);
    check("hi_rst_idle", 256'(bus.in_ready), 256'd1);
    check("hi_rst_no_valid", 256'(bus.out_valid), 256'd0);

    // Counter saturation
    force dut.word_cnt_r = 16'hFFFF;
    #1;
    release dut.word_cnt_r;
    exp_cnt = 16'hFFFF;
    check("sat_pre", 256'(bus.word_cnt), 256'h0FFFF);
    accept(w_mod4, 32'hFFFF_0000, 7'd112);
    wait_valid("lat_sat");
    handshake();
    check("sat_cnt", 256'(bus.word_cnt), 256'h0FFFF);
    check("sat_idle_valid", 256'(bus.out_valid), 256'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
